// File: rtl/boot_rom_pkg.sv
// boot_rom_pkg: shared ROM geometry defaults and response-owner encoding
package boot_rom_pkg;
    localparam int ROM_WORDS_DEF = 548;
    localparam int ROM_AW_DEF = 10;
    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;
endpackage

// File: rtl/boot_rom_rr_arb.sv
// boot_rom_rr_arb: 2-way grant logic, round-robin with BOOT_ROM_ARB_RR_EN else fixed instr-first
module boot_rom_rr_arb
    import boot_rom_pkg::*;
(
    input  logic CLK,
    input  logic RSTN,
    input  logic instr_req,
    input  logic data_req,
    output logic instr_gnt,
    output logic data_gnt
);
`ifdef BOOT_ROM_ARB_RR_EN
    owner_e ptr;
    always_ff @(posedge CLK) begin
        if (!RSTN)
            ptr <= OWN_INSTR;
        else if (instr_req && data_req)
            ptr <= (ptr == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end
    always_comb begin
        instr_gnt = RSTN && instr_req && !(data_req && ptr == OWN_DATA);
        data_gnt = RSTN && data_req && !(instr_req && ptr != OWN_DATA);
    end
`else
    logic unused_clk;
    assign unused_clk = CLK;
    always_comb begin
        instr_gnt = RSTN && instr_req;
        data_gnt = RSTN && data_req && !instr_req;
    end
`endif
endmodule

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: shares one boot ROM between instr/data ports, 1-cycle response; BOOT_ROM_ARB_RR_EN selects round-robin
module boot_rom_arbiter
    import boot_rom_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEF,
    parameter int ROM_AW = ROM_AW_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic [31:0]       data_addr_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,
    output logic              rom_csn_o,
    output logic [ROM_AW-1:0] rom_a_o,
    input  logic [31:0]       rom_q_i
);
    logic instr_gnt, data_gnt, gnt, hit, err_q, ivld, dvld;
    logic [ROM_AW-1:0] idx, a_q;
    owner_e owner_q;
    logic unused_addr;
    assign unused_addr = ^{instr_addr_i[31:ROM_AW+2], instr_addr_i[1:0],
                           data_addr_i[31:ROM_AW+2], data_addr_i[1:0]};
    boot_rom_rr_arb u_arb (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .instr_req (instr_req_i),
        .data_req  (data_req_i),
        .instr_gnt (instr_gnt),
        .data_gnt  (data_gnt)
    );
    always_comb begin
        gnt = instr_gnt || data_gnt;
        idx = instr_gnt ? instr_addr_i[ROM_AW+1:2] : data_addr_i[ROM_AW+1:2];
        hit = gnt && (32'(idx) < ROM_WORDS);
        ivld = RSTN && owner_q == OWN_INSTR;
        dvld = RSTN && owner_q == OWN_DATA;
    end
    always_comb begin
        instr_gnt_o = instr_gnt;
        data_gnt_o = data_gnt;
        rom_csn_o = !hit;
        rom_a_o = hit ? idx : a_q;
        instr_rvalid_o = ivld;
        data_rvalid_o = dvld;
        instr_err_o = ivld && err_q;
        data_err_o = dvld && err_q;
        instr_rdata_o = (ivld && !err_q) ? rom_q_i : '0;
        data_rdata_o = (dvld && !err_q) ? rom_q_i : '0;
    end
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            owner_q <= OWN_NONE;
            err_q <= 1'b0;
            a_q <= '0;
        end else begin
            owner_q <= instr_gnt ? OWN_INSTR : data_gnt ? OWN_DATA : OWN_NONE;
            err_q <= gnt && !hit;
            if (hit)
                a_q <= idx;
        end
    end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb_boot_rom_arbiter: directed vectors with a response scoreboard checked by a separate monitor
module tb_boot_rom_arbiter;
    import boot_rom_pkg::*;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic instr_req = 1'b0, data_req = 1'b0;
    logic [31:0] instr_addr = '0, data_addr = '0;
    logic instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err, rom_csn;
    logic [31:0] instr_rdata, data_rdata, rom_q;
    logic [9:0] rom_a;
    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    int vec = 0;
    int errs = 0;
    always #5 CLK = ~CLK;
    boot_rom_arbiter dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .rom_csn_o      (rom_csn),
        .rom_a_o        (rom_a),
        .rom_q_i        (rom_q)
    );
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        if (a == 10'd36) return 32'h0000_0093;
        if (a == 10'd32) return 32'h0100_006F;
        if (a < 10'd3) return 32'h0000_0013;
        return {22'h2A5A5, a};
    endfunction
    always @(posedge CLK) if (!rom_csn) rom_q <= rom_word(rom_a);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        exp_t e;
        if (instr_rvalid || data_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_instr_rvalid", instr_rvalid, !e.is_data);
                chk("rsp_data_rvalid", data_rvalid, e.is_data);
                chk("rsp_rdata", e.is_data ? data_rdata : instr_rdata, e.rdata);
                chk("rsp_err", e.is_data ? data_err : instr_err, e.err);
                chk("rsp_nonowner", e.is_data ? {instr_rdata[30:0], instr_err} : {data_rdata[30:0], data_err}, 32'd0);
            end
        end
    end
    task automatic req1(input logic is_data, input logic [31:0] addr, input logic [9:0] ea,
                        input logic ecsn, input logic [31:0] ed, input logic ee);
        @(posedge CLK) #1;
        instr_req = !is_data;
        data_req = is_data;
        instr_addr = addr;
        data_addr = addr;
        @(negedge CLK);
        chk(is_data ? "data_gnt" : "instr_gnt", is_data ? data_gnt : instr_gnt, 32'd1);
        chk("other_gnt", is_data ? instr_gnt : data_gnt, 32'd0);
        chk("rom_csn", rom_csn, ecsn);
        if (!ecsn) chk("rom_a", rom_a, ea);
        sb.push_back('{is_data, ed, ee});
    endtask
    task automatic idle();
        @(posedge CLK) #1;
        instr_req = 1'b0;
        data_req = 1'b0;
    endtask
    initial begin
        logic exp_d;
        instr_req = 1'b1;
        instr_addr = 32'h90;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_gnt", {instr_gnt, data_gnt}, 32'd0);
        chk("rst_csn", rom_csn, 32'd1);
        chk("rst_rom_a", rom_a, 32'd0);
        chk("rst_rvalid", {instr_rvalid, data_rvalid, instr_err, data_err}, 32'd0);
        chk("rst_rdata", instr_rdata | data_rdata, 32'd0);
        @(posedge CLK) #1;
        instr_req = 1'b0;
        RSTN = 1'b1;
        @(posedge CLK) #1;
        instr_req = 1'b1;
        data_req = 1'b1;
        instr_addr = 32'h0;
        data_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
`ifdef BOOT_ROM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = 1'b0;
`endif
            chk("arb_instr_gnt", instr_gnt, !exp_d);
            chk("arb_data_gnt", data_gnt, exp_d);
            chk("arb_rom_a", rom_a, exp_d ? 32'd32 : 32'd0);
            if (exp_d) sb.push_back('{1'b1, 32'h0100_006F, 1'b0});
            else sb.push_back('{1'b0, 32'h0000_0013, 1'b0});
            @(posedge CLK);
        end
        #1;
        instr_req = 1'b0;
        data_req = 1'b0;
        idle();
        req1(1'b0, 32'h90, 10'd36, 1'b0, 32'h0000_0093, 1'b0);
        idle();
        req1(1'b1, 32'h82, 10'd32, 1'b0, 32'h0100_006F, 1'b0);
        idle();
        req1(1'b1, 32'hFFC, 10'd0, 1'b1, 32'h0, 1'b1);
        idle();
        @(negedge CLK);
        chk("idle_csn", rom_csn, 32'd1);
        chk("idle_rom_a_hold", rom_a, 32'd32);
        req1(1'b0, 32'h0, 10'd0, 1'b0, 32'h0000_0013, 1'b0);
        req1(1'b0, 32'h4, 10'd1, 1'b0, 32'h0000_0013, 1'b0);
        req1(1'b0, 32'h8, 10'd2, 1'b0, 32'h0000_0013, 1'b0);
        idle();
        repeat (2) @(posedge CLK);
        @(posedge CLK) #1;
        instr_req = 1'b1;
        instr_addr = 32'h90;
        @(negedge CLK);
        chk("prerst_gnt", instr_gnt, 32'd1);
        @(posedge CLK) #1;
        instr_req = 1'b0;
        RSTN = 1'b0;
        @(negedge CLK);
        chk("midrst_rvalid", {instr_rvalid, data_rvalid}, 32'd0);
        @(posedge CLK) #1;
        RSTN = 1'b1;
        @(negedge CLK);
        chk("postrst_owner", 32'(dut.owner_q), 32'(OWN_NONE));
        chk("postrst_csn", rom_csn, 32'd1);
        chk("postrst_rvalid", {instr_rvalid, data_rvalid}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/boot_rom_arbiter.md
BOOT_ROM_ARBITER -- requirements
Module: boot_rom_arbiter

Interface
REQ-001 The block SHALL have the parameter ROM_WORDS, default 548, giving the number of valid ROM words.
REQ-002 The block SHALL have the parameter ROM_AW, default 10, giving the ROM word-address width.
REQ-003 The block SHALL have the port CLK  input  1  single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have the port RSTN  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have the port instr_req_i  input  1  instruction-port request.
REQ-006 The block SHALL have the port instr_addr_i  input  32  instruction-port byte address.
REQ-007 The block SHALL have the port instr_gnt_o  output  1  instruction-port grant (combinational).
REQ-008 The block SHALL have the port instr_rvalid_o  output  1  instruction-port response valid.
REQ-009 The block SHALL have the port instr_rdata_o  output  32  instruction-port read data.
REQ-010 The block SHALL have the port instr_err_o  output  1  instruction-port error, qualified by rvalid.
REQ-011 The block SHALL have the port data_req_i  input  1  data-port request.
REQ-012 The block SHALL have the port data_addr_i  input  32  data-port byte address.
REQ-013 The block SHALL have the port data_gnt_o  output  1  data-port grant (combinational).
REQ-014 The block SHALL have the port data_rvalid_o  output  1  data-port response valid.
REQ-015 The block SHALL have the port data_rdata_o  output  32  data-port read data.
REQ-016 The block SHALL have the port data_err_o  output  1  data-port error, qualified by rvalid.
REQ-017 The block SHALL have the port rom_csn_o  output  1  ROM chip select, active-low.
REQ-018 The block SHALL have the port rom_a_o  output  ROM_AW  ROM word address.
REQ-019 The block SHALL have the port rom_q_i  input  32  ROM data, valid one cycle after CSN is low.

Function
REQ-020 Word index SHALL be addr[ROM_AW+1:2]; addr[1:0] and addr[31:ROM_AW+2] SHALL be ignored.
REQ-021 The block SHALL assert at most one gnt per cycle; a gnt SHALL only be asserted for a requester whose req is high.
REQ-022 A requester SHALL hold req and addr stable until gnt; the grant SHALL be given in the same cycle if the ROM port is free.
REQ-023 In a grant cycle with index < ROM_WORDS, the block SHALL drive rom_csn_o=0 and rom_a_o=index.
REQ-024 In a grant cycle with index >= ROM_WORDS, the block SHALL keep rom_csn_o=1.
REQ-025 Exactly one cycle after a grant, the owner's rvalid SHALL be high for one cycle.
REQ-026 For an in-range grant, the response SHALL carry rdata=rom_q_i and err=0.
REQ-027 For an out-of-range grant, the response SHALL carry rdata=0 and err=1.
REQ-028 A non-owner's rvalid, rdata and err SHALL all be 0.
REQ-029 A response register SHALL hold the owner (NONE/INSTR/DATA) and an err flag.
REQ-030 Back-to-back grants SHALL be supported: a new grant MAY be given in the same cycle as the previous response (throughput 1 word per cycle).
REQ-031 When idle (no grant), rom_csn_o SHALL be 1 and rom_a_o SHALL hold its last value.
REQ-032 When only one port is requesting, that port SHALL be granted.
REQ-033 When both ports request, the winner SHALL be set by the arbitration policy (REQ-037/REQ-038).
REQ-034 Reset SHALL take effect mid-transfer; an outstanding response SHALL be discarded and no rvalid SHALL be emitted after reset.

Reset
REQ-035 While RSTN=0 at a clock edge, the block SHALL clear the owner to NONE, the err flag to 0, and the round-robin pointer to INSTR.
REQ-036 During and after reset, the block SHALL drive all gnt, rvalid, err and rdata outputs to 0, rom_csn_o=1 and rom_a_o=0 (gnt forced low while RSTN=0).

Configuration
REQ-037 With BOOT_ROM_ARB_RR_EN defined, contention SHALL be round-robin:
- The pointer names the preferred port.
- After each contended grant, the pointer SHALL move to the other port.
- Uncontended grants SHALL NOT move the pointer.
REQ-038 Without BOOT_ROM_ARB_RR_EN, priority SHALL be fixed (instr over data) and the pointer SHALL be absent.

Structure
REQ-039 The shared package boot_rom_pkg SHALL hold ROM_WORDS_DEF, ROM_AW_DEF and the owner enum (OWN_NONE, OWN_INSTR, OWN_DATA).
REQ-040 The 2-way arbitration logic (including the RR pointer) SHALL be the sub-module boot_rom_rr_arb; the response pipeline and range check SHALL stay in the top level.

Verification
REQ-041 The bench SHALL cover: instr_req, addr 0x90 -> gnt same cycle, rom_a_o=36, instr_rvalid next cycle with rdata=0x00000093, err=0.
REQ-042 The bench SHALL cover: data_req, addr 0x82 -> rom_a_o=32, data_rdata=0x0100006F (low bits ignored).
REQ-043 The bench SHALL cover: data_req, addr 0xFFC -> rom_csn_o stays 1, data_rvalid=1, err=1, rdata=0.
REQ-044 The bench SHALL cover: both requesting for 4 cycles, addrs 0x0/0x80 -> with RR_EN grants alternate I,D,I,D; without RR_EN, instr is granted all 4 cycles and data starves.
REQ-045 The bench SHALL cover: instr streaming addresses 0x0,0x4,0x8 in consecutive cycles -> three consecutive rvalid cycles, each rdata=0x00000013.
REQ-046 The bench SHALL cover: RSTN low in the cycle after a grant -> no rvalid; after release, owner=NONE and rom_csn_o=1.
